// File: rtl/memory_ctrl_axil_regs.sv
// memory_ctrl_axil_regs
// AXI4-Lite responder holding the CNN memory controller's CTRL/BASE/LEN/STATUS
// registers. Produces a one-cycle start pulse and a sticky DONE flag/interrupt
// for the DMA engine. Read and write channels run as independent two-state FSMs;
// every output is driven from flops, never from a bus input.
module memory_ctrl_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            start_o,
  output logic                            irq_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   base_addr_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   xfer_len_o,
  input  logic                            busy_i,
  input  logic                            done_i
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e         wstate_q, wstate_d;
  rstate_e         rstate_q, rstate_d;
  logic            alive_q;
  logic            aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [1:0]      awaddr_q, awaddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            irq_en_q, irq_en_d;
  logic [DW-1:0]   base_q, base_d, len_q, len_d;
  logic            done_q, done_d;
  logic            start_q, start_d;

  logic            aw_hs, w_hs, ar_hs, w1c;
  logic [1:0]      cmt_addr;
  logic [DW-1:0]   cmt_data, rd_mux;
  logic [SW-1:0]   cmt_strb;
  logic            unused_ok;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < SW; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Expand byte strobes to a bit mask.
  function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] strb);
    logic [DW-1:0] m;
    for (int b = 0; b < SW; b++) m[8*b +: 8] = {8{strb[b]}};
    return m;
  endfunction

  // Protection bits and byte-offset address bits carry no meaning here.
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // alive_q keeps the READYs low through reset and the first edge after it.
  assign S_AXI_AWREADY = alive_q & (wstate_q == W_IDLE) & ~aw_have_q;
  assign S_AXI_WREADY  = alive_q & (wstate_q == W_IDLE) & ~w_have_q;
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = alive_q & (rstate_q == R_IDLE);
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign start_o       = start_q;
  assign irq_o         = irq_en_q & done_q;
  assign base_addr_o   = base_q;
  assign xfer_len_o    = len_q;

  assign aw_hs    = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
  // A commit may use a half captured earlier and a half arriving this cycle.
  assign cmt_addr = aw_have_q ? awaddr_q : S_AXI_AWADDR[3:2];
  assign cmt_data = w_have_q ? wdata_q : S_AXI_WDATA;
  assign cmt_strb = w_have_q ? wstrb_q : S_AXI_WSTRB;

  // Write channel: capture AW/W independently, commit once both are held, then respond.
  always_comb begin
    wstate_d  = wstate_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    irq_en_d  = irq_en_q;
    base_d    = base_q;
    len_d     = len_q;
    start_d   = 1'b0;
    w1c       = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_have_d = 1'b1;
          awaddr_d  = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_have_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if ((aw_have_q | aw_hs) & (w_have_q | w_hs)) begin
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          wstate_d  = W_RESP;
          bresp_d   = RESP_OKAY;
          case (cmt_addr)
            2'd0: if (cmt_strb[0]) begin
              irq_en_d = cmt_data[1];
              start_d  = cmt_data[0];
            end
            2'd1: base_d = byte_merge(base_q, cmt_data, cmt_strb);
            2'd2: len_d  = byte_merge(len_q, cmt_data, cmt_strb);
            default: begin
              w1c = cmt_strb[0] & cmt_data[1];
              if ((cmt_data & strb_mask(cmt_strb) & ~DW'(2)) != '0) bresp_d = RESP_SLVERR;
            end
          endcase
        end
      end
      default: if (S_AXI_BREADY) wstate_d = W_IDLE;
    endcase
    // A done pulse wins over a simultaneous clear.
    done_d = done_i | (done_q & ~w1c);
  end

  // Register value selected by the incoming read address.
  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0: rd_mux[1] = irq_en_q;
      2'd1: rd_mux = base_q;
      2'd2: rd_mux = len_q;
      default: begin
        rd_mux[0] = busy_i;
        rd_mux[1] = done_q;
      end
    endcase
  end

  // Read channel: snapshot the register on AR handshake, hold until R handshake.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: if (ar_hs) begin
        rstate_d = R_DATA;
        rdata_d  = rd_mux;
      end
      default: if (S_AXI_RREADY) rstate_d = R_IDLE;
    endcase
  end

  // State and register storage; reset returns everything to idle/zero at once.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      alive_q   <= 1'b0;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      irq_en_q  <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      alive_q   <= 1'b1;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      irq_en_q  <= irq_en_d;
      base_q    <= base_d;
      len_q     <= len_d;
      done_q    <= done_d;
      start_q   <= start_d;
    end
  end

endmodule

// File: tb/tb_memory_ctrl_axil_regs.sv
// Bench for memory_ctrl_axil_regs: directed cases plus randomized AXI-Lite
// traffic, with expected B/R responses queued at issue time and checked by an
// independent monitor.
module tb_memory_ctrl_axil_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        start_o, irq_o, busy_i, done_i;
  logic [31:0] base_addr_o, xfer_len_o;

  always #5 clk = ~clk;

  memory_ctrl_axil_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .start_o(start_o), .irq_o(irq_o), .base_addr_o(base_addr_o), .xfer_len_o(xfer_len_o),
    .busy_i(busy_i), .done_i(done_i)
  );

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] bresp;
    logic       start;
  } bexp_t;

  bexp_t       bq[$];
  logic [31:0] rq[$];

  // Reference register state.
  logic        m_irq_en, m_done;
  logic [31:0] m_base, m_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: no handshake within cycle budget (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] idx);
    case (idx)
      2'd0:    return m_irq_en ? 32'h2 : 32'h0;
      2'd1:    return m_base;
      2'd2:    return m_len;
      default: return (m_done ? 32'h2 : 32'h0) + (busy_i ? 32'h1 : 32'h0);
    endcase
  endfunction

  // Apply a write to the reference and return the expected response.
  function automatic bexp_t m_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    bexp_t e;
    logic [31:0] enabled;
    e.bresp = 2'b00;
    e.start = 1'b0;
    enabled = 32'h0;
    for (int b = 0; b < 4; b++)
      if (s[b]) enabled = enabled | (32'hFF << (8 * b));
    case (idx)
      2'd0: if (s[0]) begin
        m_irq_en = d[1];
        e.start  = d[0];
      end
      2'd1: m_base = (m_base & ~enabled) | (d & enabled);
      2'd2: m_len  = (m_len & ~enabled) | (d & enabled);
      default: begin
        if (s[0] && d[1]) m_done = 1'b0;
        if ((d & enabled & 32'hFFFF_FFFD) != 0) e.bresp = 2'b10;
      end
    endcase
    return e;
  endfunction

  // All driver tasks start and end one time unit after a rising edge.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done, w_done, aw_hs, w_hs, hs;
    int cyc;
    bq.push_back(m_write(a[3:2], d, s));
    awaddr = a; wdata = d; wstrb = s;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 60) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) timeout("aw_w_handshake");
    repeat (b_dly) begin @(posedge clk); #1; end
    bready = 1; hs = 0; cyc = 0;
    while (!hs && cyc < 60) begin
      @(negedge clk); hs = bvalid;
      @(posedge clk); #1; cyc++;
    end
    bready = 0;
    if (!hs) timeout("b_handshake");
    check("base_addr_o", base_addr_o, m_base);
    check("xfer_len_o", xfer_len_o, m_len);
    check("irq_o_after_wr", {31'd0, irq_o}, {31'd0, m_irq_en & m_done});
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input int r_dly);
    bit hs;
    int cyc;
    rq.push_back(exp);
    araddr = a; arvalid = 1; hs = 0; cyc = 0;
    while (!hs && cyc < 60) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1; cyc++;
    end
    arvalid = 0;
    if (!hs) timeout("ar_handshake");
    repeat (r_dly) begin @(posedge clk); #1; end
    rready = 1; hs = 0; cyc = 0;
    while (!hs && cyc < 60) begin
      @(negedge clk); hs = rvalid;
      @(posedge clk); #1; cyc++;
    end
    rready = 0;
    if (!hs) timeout("r_handshake");
  endtask

  task automatic pulse_done();
    done_i = 1;
    @(posedge clk); #1;
    done_i = 0;
    m_done = 1;
    check("irq_o_after_done", {31'd0, irq_o}, {31'd0, m_irq_en});
  endtask

  // Monitor: pops expectations on handshakes and checks hold/stability rules.
  initial begin : monitor
    logic pb_v, pb_r, pr_v, pr_r;
    logic [1:0]  pb_resp;
    logic [31:0] pr_d;
    bexp_t e;
    pb_v = 0; pb_r = 0; pr_v = 0; pr_r = 0; pb_resp = 0; pr_d = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pb_v = 0; pr_v = 0;
        continue;
      end
      if (bvalid && !pb_v) begin
        if (bq.size() == 0) timeout("b_unexpected");
        else check("start_o_pulse", {31'd0, start_o}, {31'd0, bq[0].start});
      end else begin
        check("start_o_quiet", {31'd0, start_o}, 32'd0);
      end
      if (pb_v && !pb_r) begin
        check("bvalid_hold", {31'd0, bvalid}, 32'd1);
        check("bresp_hold", {30'd0, bresp}, {30'd0, pb_resp});
      end
      if (bvalid) check("aw_w_ready_while_b", {30'd0, awready, wready}, 32'd0);
      if (bvalid && bready) begin
        if (bq.size() == 0) timeout("b_unexpected_hs");
        else begin
          e = bq.pop_front();
          check("bresp", {30'd0, bresp}, {30'd0, e.bresp});
        end
      end
      if (pr_v && !pr_r) begin
        check("rvalid_hold", {31'd0, rvalid}, 32'd1);
        check("rdata_hold", rdata, pr_d);
      end
      if (rvalid) check("arready_while_r", {31'd0, arready}, 32'd0);
      if (rvalid && rready) begin
        if (rq.size() == 0) timeout("r_unexpected_hs");
        else begin
          check("rdata", rdata, rq.pop_front());
          check("rresp", {30'd0, rresp}, 32'd0);
        end
      end
      pb_v = bvalid; pb_r = bready; pb_resp = bresp;
      pr_v = rvalid; pr_r = rready; pr_d = rdata;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] exp;
    logic [3:0]  a, s;
    logic [31:0] d;
    int op;
    bit hs;
    int cyc;
    rst_n = 0;
    awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    wdata = 0; wstrb = 0; busy_i = 0; done_i = 0;
    m_irq_en = 0; m_done = 0; m_base = 0; m_len = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_readys", {29'd0, awready, wready, arready}, 32'd0);
    check("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    check("rst_start_irq", {30'd0, start_o, irq_o}, 32'd0);
    check("rst_base", base_addr_o, 32'd0);
    check("rst_len", xfer_len_o, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resps", {28'd0, bresp, rresp}, 32'd0);
    rst_n = 1;
    #1 check("ready_before_edge", {29'd0, awready, wready, arready}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {29'd0, awready, wready, arready}, 32'h7);

    // Basic write/read-back, both channel orderings.
    do_write(4'h4, 32'h1234_5678, 4'hF, 0, 0, 0);
    do_write(4'h8, 32'h0000_0100, 4'hF, 3, 0, 1);
    do_read(4'h4, 32'h1234_5678, 0);
    do_read(4'h8, 32'h0000_0100, 2);
    do_write(4'h8, 32'h0000_0200, 4'hF, 0, 3, 0);
    do_read(4'hA, m_read(2'd2), 1);

    // Byte strobe.
    do_write(4'h4, 32'h0, 4'hF, 0, 0, 0);
    do_write(4'h4, 32'hAABB_CCDD, 4'b0010, 0, 0, 0);
    do_read(4'h4, 32'h0000_CC00, 0);

    // START pulse, IRQ, DONE sticky and W1C.
    do_write(4'h0, 32'h3, 4'hF, 0, 0, 2);
    do_read(4'h0, 32'h2, 0);
    pulse_done();
    do_read(4'hC, 32'h2, 0);
    do_write(4'hC, 32'h2, 4'hF, 1, 0, 0);
    check("irq_cleared", {31'd0, irq_o}, 32'd0);
    do_read(4'hC, 32'h0, 0);
    do_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    busy_i = 1;
    do_read(4'hC, 32'h1, 0);
    busy_i = 0;

    // Long backpressure on both response channels.
    do_write(4'h8, 32'h5555_AAAA, 4'hF, 0, 0, 10);
    do_read(4'h8, 32'h5555_AAAA, 10);

    // Read and write commit the same edge: read sees the old value.
    exp = m_read(2'd1);
    fork
      do_write(4'h4, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
      do_read(4'h4, exp, 0);
    join
    do_read(4'h4, 32'hCAFE_F00D, 0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      a  = 4'($urandom_range(0, 15));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      if (op < 4) do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op < 8) do_read(a, m_read(a[3:2]), $urandom_range(0, 3));
      else if (op == 8) pulse_done();
      else begin
        busy_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end

    // Reset while a read response is pending.
    busy_i = 0;
    do_write(4'h8, 32'h0BAD_0BAD, 4'hF, 0, 0, 0);
    araddr = 4'h8; arvalid = 1; hs = 0; cyc = 0;
    while (!hs && cyc < 60) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1; cyc++;
    end
    arvalid = 0;
    if (!hs) timeout("ar_before_reset");
    repeat (2) begin @(posedge clk); #1; end
    check("rvalid_before_rst", {31'd0, rvalid}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("rvalid_async_rst", {31'd0, rvalid}, 32'd0);
    check("readys_in_rst", {29'd0, awready, wready, arready}, 32'd0);
    check("len_in_rst", xfer_len_o, 32'd0);
    check("base_in_rst", base_addr_o, 32'd0);
    rq.delete();
    m_irq_en = 0; m_done = 0; m_base = 0; m_len = 0;
    @(posedge clk); #3 rst_n = 1;
    #1 check("arready_pre_edge", {31'd0, arready}, 32'd0);
    @(posedge clk); #1;
    check("arready_post_rst", {31'd0, arready}, 32'd1);
    for (int r = 0; r < 4; r++) do_read(4'(r * 4), 32'd0, 0);

    repeat (4) @(posedge clk);
    check("b_queue_drained", bq.size(), 32'd0);
    check("r_queue_drained", rq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
